// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the device receiver.
package ps2_pkg;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_FRAME_FALLS = 11;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF pad synchronizer with glitch-qualified fall/rise strobes.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic sync_o,
  output logic fall_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a fake fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= pad_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Edge needs two consecutive samples at the new level: 1-cycle glitches drop out.
  assign sync_o = s2_q;
  assign fall_o = prev_q & ~s2_q & ~s1_q;
  assign rise_o = ~prev_q & s2_q & s1_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain via output enables).
// Optional frame watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_MS  = 15
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       PS2_KBCLK,
  input  logic       PS2_KBDAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam logic [3:0] LAST_DATA = 4'(PS2_DATA_BITS);
  localparam logic [3:0] STOP_IDX  = 4'(PS2_FRAME_FALLS - 2);

  ps2_tx_state_e state_q, state_d;

  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [INH_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             nack_q, nack_d;
  logic             done_c;
  logic             err_c;

  logic clk_sync, clk_fall, clk_rise;
  logic dat_sync, dat_fall, dat_rise;
  logic tmo_hit;

  ps2_sync_edge u_clk_sync (
    .clk    (CLOCK),
    .rst_n  (rst_n),
    .pad_i  (PS2_KBCLK),
    .sync_o (clk_sync),
    .fall_o (clk_fall),
    .rise_o (clk_rise)
  );

  ps2_sync_edge u_dat_sync (
    .clk    (CLOCK),
    .rst_n  (rst_n),
    .pad_i  (PS2_KBDAT),
    .sync_o (dat_sync),
    .fall_o (dat_fall),
    .rise_o (dat_rise)
  );

  // Device samples on rising clock edges; the host only acts on falls.
  logic unused_edges;
  assign unused_edges = ^{clk_rise, dat_rise, dat_fall};

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO_CYC = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q inside {REQ, SHIFT, ACK, WAIT_IDLE})
      tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_MS;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    nack_d   = nack_q;
    done_c   = 1'b0;
    err_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          data_d   = tx_data;
          par_d    = odd_parity(tx_data);
          cnt_d    = INH_W'(INHIBIT_CYC - 1);
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == '0) begin
          dat_oe_d = 1'b1;
          state_d  = REQ;
        end else begin
          cnt_d = cnt_q - INH_W'(1);
        end
      end
      REQ: begin
        clk_oe_d = 1'b0;
        bit_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (clk_fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < LAST_DATA) begin
            dat_oe_d = ~data_q[bit_q[2:0]];
          end else if (bit_q == LAST_DATA) begin
            dat_oe_d = ~par_q;
          end else if (bit_q == STOP_IDX) begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          nack_d  = dat_sync;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Done fires while still busy so tx_ready rises one cycle later.
        if (clk_sync && dat_sync) begin
          done_c  = 1'b1;
          err_c   = nack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_c   = 1'b1;
      err_c    = 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      nack_q   <= nack_d;
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_done    = done_c;
  assign tx_err     = err_c;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural keyboard model.
module tb_ps2_host_tx;

  localparam int CLK_HZ = 50_000_000;
  localparam int INH    = CLK_HZ / 1_000_000 * 100;

  logic       CLOCK;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       dev_clk_lo;
  logic       dev_dat_lo;
  logic       kbclk;
  logic       kbdat;

  int checks;
  int errors;
  int done_cnt;

  assign kbclk = ~(ps2_clk_oe | dev_clk_lo);
  assign kbdat = ~(ps2_dat_oe | dev_dat_lo);

  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .INHIBIT_US  (100),
    .TIMEOUT_MS  (15)
  ) dut (
    .CLOCK      (CLOCK),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .PS2_KBCLK  (kbclk),
    .PS2_KBDAT  (kbdat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  initial CLOCK = 1'b0;
  always #10 CLOCK = ~CLOCK;

  always @(negedge CLOCK) if (tx_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [7:0] b);
    int n;
    @(negedge CLOCK);
    chk("ready_idle", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLOCK);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 1000) begin
      @(negedge CLOCK);
      n++;
    end
    chk("inhibit_cycles", n, INH);
    chk("req_both_low", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b11);
    @(negedge CLOCK);
    chk("clk_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  // Keyboard: clocks the frame, samples on rising edges, ACKs on the 11th.
  task automatic dev_frame(input int half, input bit ack, input int abort_at,
                           output logic [9:0] got, output bit ok);
    int n;
    ok  = 1'b0;
    got = '0;
    n   = 0;
    while (!(kbclk === 1'b1 && kbdat === 1'b0) && n < 20000) begin
      @(negedge CLOCK);
      n++;
    end
    chk("rts_seen", 32'(n < 20000), 1);
    if (n >= 20000) return;
    repeat (half) @(negedge CLOCK);
    for (int i = 0; i < 11; i++) begin
      dev_clk_lo = 1'b1;
      tx_data    = 8'($urandom);
      if (i == abort_at) begin
        repeat (10) @(negedge CLOCK);
        return;
      end
      repeat (half) @(negedge CLOCK);
      if (i < 10) got[i] = kbdat;
      dev_clk_lo = 1'b0;
      if (i == 10) begin
        dev_dat_lo = 1'b0;
        break;
      end
      if (i == 9 && ack) dev_dat_lo = 1'b1;
      repeat (half) @(negedge CLOCK);
    end
    ok = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input int half, input bit ack);
    logic [9:0] got;
    bit         ok;
    logic       pexp;
    int         n;
    pexp = (($countones(b) % 2) == 0);
    request(b);
    dev_frame(half, ack, -1, got, ok);
    chk("frame_complete", 32'(ok), 1);
    chk("data_bits", 32'(got[7:0]), 32'(b));
    chk("parity_bit", 32'(got[8]), 32'(pexp));
    chk("stop_bit", 32'(got[9]), 1);
    n = 0;
    while (tx_done !== 1'b1 && n < 500) begin
      @(negedge CLOCK);
      n++;
    end
    chk("done_seen", 32'(n < 500), 1);
    if (n < 500) begin
      chk("tx_err", 32'(tx_err), 32'(!ack));
      chk("ready_low_at_done", 32'(tx_ready), 0);
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      @(negedge CLOCK);
      tx_valid = 1'b0;
      chk("done_one_cycle", 32'(tx_done), 0);
      chk("ready_after_done", 32'(tx_ready), 1);
      chk("valid_at_done_ignored", 32'(busy), 0);
    end
  endtask

  initial begin
    logic [9:0] got;
    bit         ok;
    int         d0;
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    rst_n      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    dev_clk_lo = 1'b0;
    dev_dat_lo = 1'b0;
    repeat (3) @(negedge CLOCK);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_dat_oe", 32'(ps2_dat_oe), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_err", 32'(tx_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(tx_ready), 1);
    rst_n = 1'b1;

    frame(8'hED, 2000, 1'b1);
    frame(8'h01, 15, 1'b1);
    frame(8'hFF, 15, 1'b1);
    frame(8'($urandom), 10 + int'($urandom_range(0, 20)), 1'b0);

    request(8'h00);
    dev_frame(15, 1'b1, 3, got, ok);
    chk("bit3_driven_low", 32'(ps2_dat_oe), 1);
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_clk_oe", 32'(ps2_clk_oe), 0);
    chk("abort_dat_oe", 32'(ps2_dat_oe), 0);
    chk("abort_ready", 32'(tx_ready), 1);
    dev_clk_lo = 1'b0;
    dev_dat_lo = 1'b0;
    @(negedge CLOCK);
    rst_n = 1'b1;
    repeat (50) @(negedge CLOCK);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", 32'(busy), 0);
    frame(8'hF4, 15, 1'b1);

`ifndef PS2_TX_TIMEOUT_EN
    d0 = done_cnt;
    request(8'hAA);
    repeat (1000) @(negedge CLOCK);
    chk("silent_busy", 32'(busy), 1);
    chk("silent_no_done", done_cnt - d0, 0);
    rst_n = 1'b0;
    @(negedge CLOCK);
    rst_n = 1'b1;
`endif

    repeat (5) @(negedge CLOCK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
